// File: rtl/regfile_write_arbiter_if.sv
// Request/grant bundle between the write requesters, the arbiter and the
// register file write port. sp is fed back from the register file.
interface regfile_write_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int DEST_W = 3,
  parameter int NREQ   = 3
);
  logic [NREQ-1:0]        req;
  logic [NREQ*DEST_W-1:0] req_dest;
  logic [NREQ*WIDTH-1:0]  req_data;
  logic [NREQ-1:0]        req_sp_adj;
  logic [WIDTH-1:0]       sp;
  logic [NREQ-1:0]        ack;
  logic [DEST_W-1:0]      regDest;
  logic [WIDTH-1:0]       DataWrite;
  logic                   regWrite;
  logic                   busy;

  modport master (
    output req, req_dest, req_data, req_sp_adj, sp,
    input  ack, regDest, DataWrite, regWrite, busy
  );

  modport slave (
    input  req, req_dest, req_data, req_sp_adj, sp,
    output ack, regDest, DataWrite, regWrite, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register file write port, with
// sp read-modify-write and a one-cycle interlock after any sp write.

// Per-requester lane: eligibility and effective write destination/data.
module regfile_write_arbiter_lane #(
  parameter int WIDTH   = 16,
  parameter int DEST_W  = 3,
  parameter int SP_ADDR = 5
) (
  input  logic              i_req,
  input  logic              i_sp_adj,
  input  logic              i_sp_hold,
  input  logic [DEST_W-1:0] i_dest,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [WIDTH-1:0]  i_sp,
  output logic              o_elig,
  output logic [DEST_W-1:0] o_dest,
  output logic [WIDTH-1:0]  o_data
);
  // sp adjusts wait out the hold cycle so they never read a stale sp
  assign o_elig = i_req & ~(i_sp_adj & i_sp_hold);
  assign o_dest = i_sp_adj ? DEST_W'(SP_ADDR) : i_dest;
  // two's complement offset, wraps silently
  assign o_data = i_sp_adj ? (i_sp + i_data) : i_data;
endmodule

module regfile_write_arbiter #(
  parameter int WIDTH   = 16,
  parameter int DEST_W  = 3,
  parameter int SP_ADDR = 5,
  parameter int NREQ    = 3
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  regfile_write_arbiter_if.slave   bus
);
  localparam int PTR_W = 2;
  localparam logic [DEST_W-1:0] SP_IDX = DEST_W'(SP_ADDR);

  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_sp_hold;
  logic              r_we;
  logic [DEST_W-1:0] r_dest;
  logic [WIDTH-1:0]  r_data;

  logic [NREQ-1:0]              w_elig;
  logic [NREQ-1:0]              w_ack;
  logic [NREQ-1:0][DEST_W-1:0]  w_lane_dest;
  logic [NREQ-1:0][WIDTH-1:0]   w_lane_data;
  logic [PTR_W-1:0]             w_gnt;
  logic                         w_any;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    regfile_write_arbiter_lane #(
      .WIDTH(WIDTH), .DEST_W(DEST_W), .SP_ADDR(SP_ADDR)
    ) u_lane (
      .i_req     (bus.req[g]),
      .i_sp_adj  (bus.req_sp_adj[g]),
      .i_sp_hold (r_sp_hold),
      .i_dest    (bus.req_dest[g*DEST_W +: DEST_W]),
      .i_data    (bus.req_data[g*WIDTH +: WIDTH]),
      .i_sp      (bus.sp),
      .o_elig    (w_elig[g]),
      .o_dest    (w_lane_dest[g]),
      .o_data    (w_lane_data[g])
    );
  end

  // first eligible lane at or above rr_ptr, wrapping modulo NREQ
  always_comb begin
    int idx;
    w_ack = '0;
    w_gnt = '0;
    w_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_any && w_elig[idx]) begin
        w_any = 1'b1;
        w_gnt = PTR_W'(idx);
      end
    end
    if (w_any) w_ack[w_gnt] = 1'b1;
  end

  // registered write port, pointer advance and sp interlock
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rr_ptr  <= '0;
      r_sp_hold <= 1'b0;
      r_we      <= 1'b0;
      r_dest    <= '0;
      r_data    <= '0;
    end else begin
      r_we      <= w_any;
      r_sp_hold <= w_any && (w_lane_dest[w_gnt] == SP_IDX);
      if (w_any) begin
        r_rr_ptr <= (w_gnt == PTR_W'(NREQ-1)) ? '0 : w_gnt + 1'b1;
        r_dest   <= w_lane_dest[w_gnt];
        r_data   <= w_lane_data[w_gnt];
      end
    end
  end

  // grants are suppressed while reset is asserted
  assign bus.ack       = RST_N ? w_ack : '0;
  assign bus.busy      = |bus.req;
  assign bus.regWrite  = r_we;
  assign bus.regDest   = r_dest;
  assign bus.DataWrite = r_data;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed + random bench for regfile_write_arbiter with a behavioural
// model of the arbitration rules and of the register file holding sp.
module tb_regfile_write_arbiter;
  localparam int WIDTH = 16, DEST_W = 3, NREQ = 3, SP_ADDR = 5;

  logic CLK = 1'b0;
  logic RST_N;

  regfile_write_arbiter_if #(.WIDTH(WIDTH), .DEST_W(DEST_W), .NREQ(NREQ)) bus();

  regfile_write_arbiter #(
    .WIDTH(WIDTH), .DEST_W(DEST_W), .SP_ADDR(SP_ADDR), .NREQ(NREQ)
  ) u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int nvec  = 0;
  int nfail = 0;

  // requester side
  logic [2:0]  t_req;
  logic [2:0]  t_adj;
  logic [2:0]  t_dest [3];
  logic [15:0] t_data [3];

  // model: register file plus arbiter-visible state
  logic [15:0] rf [8];
  int          m_rr;
  bit          m_hold;
  bit          m_we;
  logic [2:0]  m_dest;
  logic [15:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req        = t_req;
    bus.req_sp_adj = t_adj;
    for (int i = 0; i < 3; i++) begin
      bus.req_dest[i*3 +: 3]   = t_dest[i];
      bus.req_data[i*16 +: 16] = t_data[i];
    end
    bus.sp = rf[SP_ADDR];
  endtask

  task automatic model_reset();
    m_rr = 0; m_hold = 0; m_we = 0; m_dest = '0; m_data = '0;
  endtask

  // one clock: check ack against model, advance, check registered outputs
  task automatic cycle(input bit keep);
    int g;
    logic [15:0] sp_now;
    drive();
    #1;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_rr + k) % 3;
      if (g < 0 && t_req[i] && !(t_adj[i] && m_hold)) g = i;
    end
    chk("ack", {29'd0, bus.ack}, (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("busy", {31'd0, bus.busy}, {31'd0, |t_req});
    sp_now = rf[SP_ADDR];
    @(posedge CLK);
    if (m_we) rf[m_dest] = m_data;
    if (g >= 0) begin
      m_we = 1;
      if (t_adj[g]) begin
        m_dest = 3'(SP_ADDR);
        m_data = sp_now + t_data[g];
      end else begin
        m_dest = t_dest[g];
        m_data = t_data[g];
      end
      m_hold = (m_dest == 3'(SP_ADDR));
      m_rr   = (g + 1) % 3;
      if (!keep) t_req[g] = 1'b0;
    end else begin
      m_we = 0;
      m_hold = 0;
    end
    #1;
    chk("regWrite", {31'd0, bus.regWrite}, {31'd0, m_we});
    chk("regDest", {29'd0, bus.regDest}, {29'd0, m_dest});
    chk("DataWrite", {16'd0, bus.DataWrite}, {16'd0, m_data});
  endtask

  initial begin
    RST_N = 1'b1;
    t_req = '0; t_adj = '0;
    for (int i = 0; i < 3; i++) begin t_dest[i] = '0; t_data[i] = '0; end
    for (int i = 0; i < 8; i++) rf[i] = '0;
    model_reset();

    // reset with all requests pending
    t_req = 3'b111;
    drive();
    #1 RST_N = 1'b0;
    #2;
    chk("rst_ack", {29'd0, bus.ack}, 32'd0);
    chk("rst_regWrite", {31'd0, bus.regWrite}, 32'd0);
    chk("rst_regDest", {29'd0, bus.regDest}, 32'd0);
    chk("rst_DataWrite", {16'd0, bus.DataWrite}, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;

    // round robin with continuous plain writes
    t_dest[0] = 3'd1; t_dest[1] = 3'd2; t_dest[2] = 3'd3;
    t_data[0] = 16'h1111; t_data[1] = 16'h2222; t_data[2] = 16'h3333;
    t_req = 3'b111;
    repeat (6) cycle(1'b1);
    t_req = '0;
    repeat (2) cycle(1'b0);

    // sp adjust, negative offset
    rf[SP_ADDR] = 16'h0100;
    t_adj = 3'b010; t_data[1] = 16'hFFFE; t_req = 3'b010;
    cycle(1'b0);
    chk("spadj_dest", {29'd0, bus.regDest}, 32'd5);
    chk("spadj_data", {16'd0, bus.DataWrite}, 32'h00FE);
    repeat (2) cycle(1'b0);

    // sp adjust, wrap past 0xFFFF
    rf[SP_ADDR] = 16'hFFFF;
    t_data[1] = 16'h0002; t_req = 3'b010;
    cycle(1'b0);
    chk("spwrap_data", {16'd0, bus.DataWrite}, 32'h0001);
    repeat (2) cycle(1'b0);

    // back-to-back sp adjusts interlock
    rf[SP_ADDR] = 16'h0200;
    t_adj = 3'b011; t_data[0] = 16'h0002; t_data[1] = 16'h0002; t_req = 3'b011;
    repeat (3) cycle(1'b0);
    chk("interlock_dest", {29'd0, bus.regDest}, 32'd5);
    chk("interlock_data", {16'd0, bus.DataWrite}, 32'h0204);
    repeat (2) cycle(1'b0);

    // plain request passes an sp adjust during the hold cycle
    t_adj = '0; t_dest[0] = 3'd5; t_data[0] = 16'h0AAA; t_req = 3'b001;
    cycle(1'b0);
    t_adj = 3'b010; t_data[1] = 16'h0010;
    t_dest[2] = 3'd6; t_data[2] = 16'h6666; t_req = 3'b110;
    cycle(1'b0);
    chk("mixed_plain", {16'd0, bus.DataWrite}, 32'h6666);
    cycle(1'b0);
    chk("mixed_adj", {16'd0, bus.DataWrite}, 32'h0ABA);
    repeat (2) cycle(1'b0);

    // random traffic obeying the hold-until-acked protocol
    repeat (400) begin
      for (int i = 0; i < 3; i++) begin
        if (!t_req[i] && $urandom_range(0, 2) != 0) begin
          t_req[i]  = 1'b1;
          t_dest[i] = 3'($urandom_range(0, 7));
          t_data[i] = 16'($urandom);
          t_adj[i]  = ($urandom_range(0, 3) == 0);
        end
      end
      cycle(1'b0);
    end

    // async reset in the middle of a write cycle
    t_adj = '0; t_dest[0] = 3'd3; t_data[0] = 16'hBEEF; t_req = 3'b001;
    cycle(1'b0);
    @(negedge CLK) RST_N = 1'b0;
    model_reset();
    t_req = 3'b111;
    drive();
    #1;
    chk("midrst_regWrite", {31'd0, bus.regWrite}, 32'd0);
    chk("midrst_ack", {29'd0, bus.ack}, 32'd0);
    @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    t_adj = 3'b111; t_data[0] = 16'h0004; t_data[1] = 16'h0008; t_data[2] = 16'h0010;
    t_req = 3'b111;
    repeat (6) cycle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
